// File: rtl/conv3x3_mc_engine.sv
// 3x3 window convolution over OCH parallel output channels: multiply, sum, multi-channel
// accumulate, then bias, round/shift, optional ReLU and saturation onto a valid/ready stream.
module conv3x3_mc_engine #(
  parameter int unsigned DW   = 8,
  parameter int unsigned OCH  = 2,
  parameter int unsigned ACCW = 24,
  parameter int unsigned CINW = 8,
  localparam int unsigned OchW = (OCH > 1) ? $clog2(OCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        cfg_shift_i,
  input  logic              cfg_relu_i,
  input  logic              wt_we_i,
  input  logic [OchW-1:0]   wt_och_i,
  input  logic [3:0]        wt_tap_i,
  input  logic [ACCW-1:0]   wt_data_i,
  input  logic [9*DW-1:0]   win_data_i,
  input  logic              win_valid_i,
  input  logic              win_last_i,
  output logic              win_ready_o,
  output logic [OCH*DW-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              wt_err_o
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned XW = ACCW + 1;

  logic signed [DW-1:0]   wt_q   [OCH][9];
  logic signed [ACCW-1:0] bias_q [OCH];
  logic signed [PW-1:0]   prod_q [OCH][9];
  logic signed [ACCW-1:0] sum_d  [OCH];
  logic signed [ACCW-1:0] sum_q  [OCH];
  logic signed [ACCW-1:0] acc_d  [OCH];
  logic signed [ACCW-1:0] acc_q  [OCH];
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] v_sat;
  logic signed [ACCW:0]   v_rnd;
  logic signed [ACCW:0]   v_sh;
  logic [ACCW:0]          rnd;

  logic [OCH*DW-1:0] res_d;
  logic [OCH*DW-1:0] out_data_q;
  logic              out_valid_q;
  logic              wt_err_q;
  logic              s1_valid_q, s1_last_q, s1_first_q;
  logic              s2_valid_q, s2_last_q, s2_first_q;
  logic              s3_valid_q, s3_last_q;
  logic [CINW-1:0]   cin_cnt_q, cin_cnt_d;
  logic              advance;
  logic              first_beat;
  logic              wr_en;

  // Clamp a one-bit-wider sum back into the signed accumulator range.
  function automatic logic [ACCW-1:0] sat_acc(input logic [ACCW:0] x);
    if (x[ACCW] != x[ACCW-1]) begin
      return x[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
    return x[ACCW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_out(input logic [ACCW:0] x);
    if ((&x[ACCW:DW-1]) || !(|x[ACCW:DW-1])) begin
      return x[DW-1:0];
    end
    return x[ACCW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign advance     = !out_valid_q || out_ready_i;
  assign win_ready_o = advance;
  // A zero count means the next accepted beat opens a new output pixel.
  assign first_beat  = (cin_cnt_q == '0);
  assign busy_o      = s1_valid_q || s2_valid_q || s3_valid_q || !first_beat;
  assign wr_en       = wt_we_i && !busy_o;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign wt_err_o    = wt_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < OCH; c++) begin
        for (int k = 0; k < 9; k++) begin
          wt_q[c][k] <= '0;
        end
        bias_q[c] <= '0;
      end
    end else if (wr_en) begin
      for (int c = 0; c < OCH; c++) begin
        if (wt_och_i == OchW'(c)) begin
          for (int k = 0; k < 9; k++) begin
            if (wt_tap_i == 4'(k)) begin
              wt_q[c][k] <= wt_data_i[DW-1:0];
            end
          end
          if (wt_tap_i == 4'd9) begin
            bias_q[c] <= wt_data_i;
          end
        end
      end
    end
  end

  // Products carry no reset: they are qualified by s1_valid_q downstream.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      for (int c = 0; c < OCH; c++) begin
        for (int k = 0; k < 9; k++) begin
          prod_q[c][k] <= PW'(wt_q[c][k]) * PW'($signed(win_data_i[k*DW +: DW]));
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < OCH; c++) begin
      sum_d[c] = '0;
      for (int k = 0; k < 9; k++) begin
        sum_d[c] = sum_d[c] + ACCW'(prod_q[c][k]);
      end
    end
  end

  always_comb begin
    base = '0;
    for (int c = 0; c < OCH; c++) begin
      base     = s2_first_q ? '0 : acc_q[c];
      acc_d[c] = sat_acc({base[ACCW-1], base} + {sum_q[c][ACCW-1], sum_q[c]});
    end
  end

  always_comb begin
    cin_cnt_d = cin_cnt_q;
    if (win_valid_i) begin
      if (win_last_i) begin
        cin_cnt_d = '0;
      end else if (cin_cnt_q != '1) begin
        cin_cnt_d = cin_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    res_d = '0;
    v_sat = '0;
    v_rnd = '0;
    v_sh  = '0;
    rnd   = (cfg_shift_i == 5'd0) ? '0 : (XW'(1) << (cfg_shift_i - 5'd1));
    for (int c = 0; c < OCH; c++) begin
      v_sat = sat_acc({acc_q[c][ACCW-1], acc_q[c]} + {bias_q[c][ACCW-1], bias_q[c]});
      v_rnd = {v_sat[ACCW-1], v_sat} + rnd;
      v_sh  = v_rnd >>> cfg_shift_i;
      if (cfg_relu_i && v_sh[ACCW]) begin
        v_sh = '0;
      end
      res_d[c*DW +: DW] = sat_out(v_sh);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_first_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      cin_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wt_err_q    <= 1'b0;
      for (int c = 0; c < OCH; c++) begin
        sum_q[c] <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      if (wt_we_i && busy_o) begin
        wt_err_q <= 1'b1;
      end
      if (advance) begin
        cin_cnt_q  <= cin_cnt_d;
        s1_valid_q <= win_valid_i;
        s1_last_q  <= win_last_i;
        s1_first_q <= first_beat;
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_first_q <= s1_first_q;
        s3_valid_q <= s2_valid_q;
        s3_last_q  <= s2_last_q;
        for (int c = 0; c < OCH; c++) begin
          sum_q[c] <= sum_d[c];
          if (s2_valid_q) begin
            acc_q[c] <= acc_d[c];
          end
        end
        if (s3_valid_q && s3_last_q) begin
          out_data_q  <= res_d;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule
